// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver (configurable data/parity/stop bits) feeding a
// receive FIFO, with sticky framing, parity and overrun flags.
module uart_rx_fifo_param #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int DEPTH        = 16,
   localparam int CW          = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_serial,
   input  logic                 rd_en_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic [CW-1:0]        count_o,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_o,
   input  logic                 clr_err_i
);

   localparam int AW  = $clog2(DEPTH);
   localparam int BCW = $clog2(CLKS_PER_BIT);
   localparam int IW  = $clog2(DATA_BITS);

   localparam logic [BCW-1:0] HALF_CNT = BCW'(CLKS_PER_BIT / 2);
   localparam logic [BCW-1:0] LAST_CNT = BCW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_BITS - 1);
   localparam logic           LAST_STP = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                 rx_meta;
   logic                 rxs;
   logic [2:0]           state;
   logic [BCW-1:0]       bit_cnt;
   logic [IW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 frame_bad;
   logic                 push_req;
   logic [DATA_BITS-1:0] push_word;

   logic                 bit_done;
   logic                 par_exp;
   logic                 parity_evt;
   logic                 stop_evt;
   logic                 last_stop;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count_next;
   logic                 pop;
   logic                 push_ok;
   logic                 overrun_evt;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rxs     <= rx_meta;
      end
   end

   assign bit_done   = (bit_cnt == LAST_CNT);
   assign par_exp    = (PARITY_MODE == 2) ? ~(^shift) : ^shift;
   assign parity_evt = (state == S_PARITY) && bit_done && (rxs != par_exp);
   assign stop_evt   = (state == S_STOP) && bit_done && !rxs;
   assign last_stop  = (state == S_STOP) && bit_done && (stop_idx == LAST_STP);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // in this block sees the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift     <= '0;
         frame_bad <= 1'b0;
         push_req  <= 1'b0;
         push_word <= '0;
      end else begin
         push_req <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state   <= S_START;
                  bit_cnt <= '0;
               end
            end
            S_START: begin
               if (bit_cnt == HALF_CNT) begin
                  bit_cnt <= '0;
                  if (rxs) begin
                     state <= S_IDLE;
                  end else begin
                     state     <= S_DATA;
                     bit_idx   <= '0;
                     frame_bad <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  bit_cnt <= '0;
                  shift   <= {rxs, shift[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == LAST_IDX) begin
                     state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                     stop_idx <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (bit_done) begin
                  bit_cnt <= '0;
                  state   <= S_STOP;
                  if (parity_evt) frame_bad <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  bit_cnt <= '0;
                  if (stop_evt) frame_bad <= 1'b1;
                  if (last_stop) begin
                     // Leave at mid-stop so a back-to-back start edge is caught.
                     state     <= S_IDLE;
                     push_req  <= !(frame_bad || stop_evt);
                     push_word <= shift;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign pop         = rd_en_i && !empty_o;
   assign push_ok     = push_req && (!full_o || pop);
   assign overrun_evt = push_req && full_o && !pop;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_next = count_o;
      case ({push_ok, pop})
         2'b10:   count_next = count_o + 1'b1;
         2'b01:   count_next = count_o - 1'b1;
         default: count_next = count_o;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
         empty_o <= 1'b1;
         full_o  <= 1'b0;
         data_o  <= '0;
      end else begin
         count_o <= count_next;
         empty_o <= (count_next == '0);
         full_o  <= (count_next == CW'(DEPTH));
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            data_o <= mem[rd_ptr];
         end
      end
   end

   // NOTE: storage array has no reset; occupancy is tracked by count/pointers,
   // and leaving it out keeps the array mappable to RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         // A new event in the clear cycle wins over the clear.
         frame_err_o  <= stop_evt    || (frame_err_o  && !clr_err_i);
         parity_err_o <= parity_evt  || (parity_err_o && !clr_err_i);
         overrun_o    <= overrun_evt || (overrun_o    && !clr_err_i);
      end
   end

endmodule

// File: doc/uart_rx_fifo_param.md
Name: uart_rx_fifo_param

Overview:
Parametrised UART receiver with an integrated receive FIFO. This is the next-generation serial-in path that feeds downstream logic.
- Generalises the fixed 8N1 receiver + FIFO pair: configurable data bits, parity, stop bits, baud divisor and FIFO depth.
- Adds framing, parity and overrun error detection, plus a fill-level output.
- Received words are pushed into the FIFO automatically; the consumer pops with rd_en_i.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (>=4); default gives 230400 baud at 100 MHz
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, 1 or 2
DEPTH, 16, FIFO entries, power of two, >=2
CW, $clog2(DEPTH+1), count_o width (derived localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
rx_serial  in  1  asynchronous serial input, idle high
rd_en_i  in  1  pop request
data_o  out  DATA_BITS  popped word, registered
empty_o  out  1  FIFO empty
full_o  out  1  FIFO full
count_o  out  CW  current FIFO occupancy
frame_err_o  out  1  sticky: a stop bit was sampled low
parity_err_o  out  1  sticky: a parity mismatch occurred
overrun_o  out  1  sticky: a valid word arrived while the FIFO was full
clr_err_i  in  1  synchronous clear of all three sticky flags

Behaviour:
- Reset values (rst=0, asynchronous): FSM=IDLE, both synchroniser flops=1, all pointers/count=0, data_o=0, empty_o=1, full_o=0, all error flags=0. Reset mid-frame abandons the frame; nothing is pushed.
- rx_serial passes through a 2-flop synchroniser. All sampling uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP. A single bit counter runs 0..CLKS_PER_BIT-1.
  - IDLE: rxs=0 -> START, counter=0.
  - START: at counter=CLKS_PER_BIT/2 (integer division), sample rxs. If 1, treat as a glitch and return to IDLE. If 0, restart the counter and go to DATA.
  - DATA: sample at each subsequent full bit period (mid-bit). Bits are LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: sample one bit. Expected value = XOR of data bits (even) or its inverse (odd). A mismatch marks the frame bad and sets parity_err_o.
  - STOP: sample STOP_BITS bits. Any 0 marks the frame bad and sets frame_err_o.
  - After the last stop sample, go to IDLE immediately. Do not wait out the remaining half bit, so back-to-back frames are accepted.
- Push: on the cycle after the last stop sample, a good frame is written to the FIFO. A bad frame is discarded.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped and overrun_o sets.
- Pop: rd_en_i=1 with empty_o=0 loads data_o from the head entry on that edge; data_o is valid the next cycle.
  - Pop while empty is ignored; data_o holds its value.
  - data_o holds its value between pops.
- Simultaneous push and pop: both occur and count_o is unchanged. A push into a full FIFO succeeds if a pop happens in the same cycle.
- Pointers are DEPTH-modulo and wrap naturally. empty_o = (count==0). full_o = (count==DEPTH). Both are registered and consistent with count_o every cycle.
- Latency: empty_o deasserts 2 cycles after the last stop-bit sample (1 cycle to push, 1 cycle for the registered flag).
- Sticky flags set on the event cycle and hold until clr_err_i=1 or reset.
  - If clr_err_i and a new error event occur in the same cycle, the set wins.
- Width rules: count_o is CW bits. No arithmetic overflow is permitted.

Test Plan:
1. Reset low then high, idle line, 8N1, 434 clk/bit. Send start + bits 0,1,0,0,1,1,1,1 + stop -> one push; empty_o=0, count_o=1; rd_en_i one cycle -> data_o=0xF2, empty_o=1.
2. Send 20 back-to-back frames 0x00..0x13 with DEPTH=16, no reads -> full_o=1 after the 16th, count_o=16, overrun_o=1. Popping 16 times yields 0x00..0x0F in order, then empty_o=1.
3. PARITY_MODE=1: send 0x03 with parity bit 1 -> parity_err_o=1, count_o stays 0. Send 0x03 with parity bit 0 -> accepted, data 0x03. Pulse clr_err_i -> flag clears.
4. STOP_BITS=2: send 0xA5 with second stop bit 0 -> frame_err_o=1, nothing pushed. The next valid frame 0x5A is pushed normally.
5. Drive a low glitch of 100 clk on an idle line -> no push, no error flags, FSM back in IDLE.
6. Assert rst mid-DATA of frame 0x77 -> all outputs return to reset values. After release, a full frame 0x3C is received correctly. A simultaneous push+pop at count_o=16 leaves count_o=16 and overrun_o=0.
